// File: rtl/nand_and_tree_pipe_if.sv
// Streaming bundle for nand_and_tree_pipe: input handshake, output handshake and
// self-check status.
interface nand_and_tree_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_inv;
    logic             out_valid;
    logic             out_ready;
    logic             s;
    logic             err;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, s, err, err_count
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, s, err, err_count
    );
endinterface

// File: rtl/nand_and_tree_pipe.sv
// Pipelined WIDTH-input AND/NAND reduction built from 2-input nand gates, one register per level.
// Define SELF_CHECK_EN to add a behavioural reference pipe with sticky err and saturating err_count.
module nand_and_tree_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic                   clk,
    input logic                   rst,
    nand_and_tree_pipe_if.slave   bus
);
    localparam int LEVELS = $clog2(WIDTH);

    function automatic int lvl_w(input int k);
        return (WIDTH + (1 << k) - 1) >> k;
    endfunction

    // Registered levels 1..LEVELS are packed back to back in one flat vector.
    function automatic int lvl_off(input int k);
        int o;
        o = 0;
        for (int j = 1; j < k; j++) o += lvl_w(j);
        return o;
    endfunction

    localparam int TOT = lvl_off(LEVELS + 1);

    logic [TOT-1:0]    tree_d;
    logic [TOT-1:0]    ld_mask;
    logic [TOT-1:0]    stage_q, stage_d;
    logic [LEVELS-1:0] valid_q, valid_d;
    logic [LEVELS-1:0] inv_q, inv_d;
    logic [LEVELS-1:0] nxt_valid, nxt_inv, ld;
    logic              stall;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int SW = lvl_w(k - 1);
        localparam int DW = lvl_w(k);
        wire [SW-1:0] src;
        if (k == 1) begin : g_src_in
            assign src = bus.in_data;
        end else begin : g_src_reg
            assign src = stage_q[lvl_off(k - 1) +: SW];
        end
        for (genvar i = 0; i < DW; i++) begin : g_node
            wire b;
            wire nab;
            wire and_o;
            if (2 * i + 1 < SW) begin : g_pair
                assign b = src[2*i+1];
            end else begin : g_pad
                assign b = 1'b1;
            end
            nand u_nand_a (nab, src[2*i], b);
            nand u_nand_b (and_o, nab, nab);
            assign tree_d[lvl_off(k) + i]  = and_o;
            assign ld_mask[lvl_off(k) + i] = ld[k-1];
        end
    end

    always_comb begin
        stall     = valid_q[LEVELS-1] && !bus.out_ready;
        nxt_valid = (valid_q << 1) | LEVELS'(bus.in_valid);
        nxt_inv   = (inv_q << 1) | LEVELS'(bus.in_inv);
        ld        = stall ? '0 : nxt_valid;
        valid_d   = stall ? valid_q : nxt_valid;
        inv_d     = (ld & nxt_inv) | (~ld & inv_q);
    end

    // A level only captures when a valid item arrives, so bubbles never pull X inward.
    always_comb begin
        stage_d = (ld_mask & tree_d) | (~ld_mask & stage_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            valid_q <= '0;
            inv_q   <= '0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
            inv_q   <= inv_d;
        end
    end

    assign bus.in_ready  = !stall;
    assign bus.out_valid = valid_q[LEVELS-1];
    assign bus.s         = stage_q[TOT-1] ^ inv_q[LEVELS-1];

`ifdef SELF_CHECK_EN
    logic [LEVELS-1:0] ref_q, ref_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ref_in;
    logic              mismatch;

    always_comb begin
        ref_in   = bus.in_inv ? ~&bus.in_data : &bus.in_data;
        ref_d    = (ld & ((ref_q << 1) | LEVELS'(ref_in))) | (~ld & ref_q);
        mismatch = valid_q[LEVELS-1] && bus.out_ready && (bus.s != ref_q[LEVELS-1]);
        err_d    = err_q | mismatch;
        cnt_d    = (mismatch && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ref_q <= ref_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.err       = err_q;
    assign bus.err_count = cnt_q;
`else
    assign bus.err       = 1'b0;
    assign bus.err_count = '0;
`endif
endmodule
